iq_freq_discriminator: RTL and testbench

Downstream stage of the IQ demodulator. Consumes the low-pass-filtered I and Q streams, 5-bit signed each, produced by two `filter_20` instances. Each instance asserts its own one-cycle output valid, so the two streams can arrive skewed. The block pairs I/Q samples and computes the cross-product frequency discriminant `d[n] = I[n-1]*Q[n] - Q[n-1]*I[n]`, optionally decimates it, and emits the discriminant and a hard chip decision to the despreader.

---
 rtl/iq_freq_discriminator.sv | 169 ++++++++++++++++
 tb/tb_iq_freq_discriminator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iq_freq_discriminator.sv
`default_nettype none
// ============================================================================
//  Module   : iq_freq_discriminator
//  Purpose  : Pairs skewed I/Q strobes and emits the cross-product frequency
//             discriminant I[n-1]*Q[n] - Q[n-1]*I[n] with optional decimation.
//  Revision : 1.0 - initial release
// ============================================================================
module iq_freq_discriminator #(
  parameter int DECIM = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [4:0] i_in,
  input  logic              i_valid,
  input  logic signed [4:0] q_in,
  input  logic              q_valid,
  output logic signed [9:0] disc_out,
  output logic              chip_out,
  output logic              out_valid,
  output logic              sync_err
);

  localparam logic [2:0] C_DEC_LAST = 3'(DECIM - 1);

  // Pairing state
  logic signed [4:0] i_pend_q, i_pend_d;
  logic signed [4:0] q_pend_q, q_pend_d;
  logic              i_flag_q, i_flag_d;
  logic              q_flag_q, q_flag_d;
  logic              sync_err_q, sync_err_d;

  // Stage 1 state
  logic signed [4:0] ip_q, ip_d;
  logic signed [4:0] qp_q, qp_d;
  logic              prev_ok_q, prev_ok_d;
  logic [2:0]        dec_cnt_q, dec_cnt_d;
  logic signed [9:0] p1_q, p1_d;
  logic signed [9:0] p2_q, p2_d;
  logic              s1_vld_q, s1_vld_d;

  // Stage 2 / output state
  logic signed [9:0] disc_q, disc_d;
  logic              chip_q, chip_d;
  logic              out_vld_q, out_vld_d;

  // Combinational helpers
  logic              w_pair;
  logic              w_computed;
  logic signed [4:0] w_i_cur;
  logic signed [4:0] w_q_cur;
  logic signed [9:0] w_i_ext, w_q_ext, w_ip_ext, w_qp_ext;
  logic signed [9:0] w_diff;

  // A strobe landing in the pairing cycle takes precedence over the held value.
  assign w_pair     = (i_valid | i_flag_q) & (q_valid | q_flag_q);
  assign w_computed = w_pair & prev_ok_q;
  assign w_i_cur    = i_valid ? i_in : i_pend_q;
  assign w_q_cur    = q_valid ? q_in : q_pend_q;

  assign w_i_ext  = {{5{w_i_cur[4]}}, w_i_cur};
  assign w_q_ext  = {{5{w_q_cur[4]}}, w_q_cur};
  assign w_ip_ext = {{5{ip_q[4]}}, ip_q};
  assign w_qp_ext = {{5{qp_q[4]}}, qp_q};

  // The true difference spans -496..496, so 10-bit modular subtraction is exact.
  assign w_diff = p1_q - p2_q;

  always_comb begin
    i_pend_d   = i_pend_q;
    q_pend_d   = q_pend_q;
    i_flag_d   = i_flag_q;
    q_flag_d   = q_flag_q;
    sync_err_d = sync_err_q | (i_valid & i_flag_q) | (q_valid & q_flag_q);

    if (i_valid) begin
      i_pend_d = i_in;
      i_flag_d = 1'b1;
    end
    if (q_valid) begin
      q_pend_d = q_in;
      q_flag_d = 1'b1;
    end
    if (w_pair) begin
      i_flag_d = 1'b0;
      q_flag_d = 1'b0;
    end
  end

  always_comb begin
    ip_d      = ip_q;
    qp_d      = qp_q;
    prev_ok_d = prev_ok_q;
    dec_cnt_d = dec_cnt_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    s1_vld_d  = 1'b0;

    if (w_pair) begin
      ip_d      = w_i_cur;
      qp_d      = w_q_cur;
      prev_ok_d = 1'b1;
      p1_d      = w_ip_ext * w_q_ext;
      p2_d      = w_qp_ext * w_i_ext;
    end
    // Skipped pairs still advance (Ip, Qp) above; only the strobe is gated.
    if (w_computed) begin
      s1_vld_d  = (dec_cnt_q == 3'd0);
      dec_cnt_d = (dec_cnt_q == C_DEC_LAST) ? 3'd0 : dec_cnt_q + 3'd1;
    end
  end

  always_comb begin
    disc_d    = disc_q;
    chip_d    = chip_q;
    out_vld_d = s1_vld_q;

    if (s1_vld_q) begin
      disc_d = w_diff;
      if (w_diff > 10'sd0) begin
        chip_d = 1'b1;
      end else if (w_diff < 10'sd0) begin
        chip_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_pend_q   <= '0;
      q_pend_q   <= '0;
      i_flag_q   <= 1'b0;
      q_flag_q   <= 1'b0;
      sync_err_q <= 1'b0;
      ip_q       <= '0;
      qp_q       <= '0;
      prev_ok_q  <= 1'b0;
      dec_cnt_q  <= 3'd0;
      p1_q       <= '0;
      p2_q       <= '0;
      s1_vld_q   <= 1'b0;
      disc_q     <= '0;
      chip_q     <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      i_pend_q   <= i_pend_d;
      q_pend_q   <= q_pend_d;
      i_flag_q   <= i_flag_d;
      q_flag_q   <= q_flag_d;
      sync_err_q <= sync_err_d;
      ip_q       <= ip_d;
      qp_q       <= qp_d;
      prev_ok_q  <= prev_ok_d;
      dec_cnt_q  <= dec_cnt_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      s1_vld_q   <= s1_vld_d;
      disc_q     <= disc_d;
      chip_q     <= chip_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign disc_out  = disc_q;
  assign chip_out  = chip_q;
  assign out_valid = out_vld_q;
  assign sync_err  = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_freq_discriminator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iq_freq_discriminator
//  Purpose  : Directed vector bench for iq_freq_discriminator (DECIM=1 and 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iq_freq_discriminator;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [4:0] i_in, q_in;
  logic              i_valid, q_valid;
  logic signed [9:0] disc1, disc2;
  logic              chip1, chip2, vld1, vld2, serr1, serr2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iq_freq_discriminator #(.DECIM(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_in(i_in), .i_valid(i_valid), .q_in(q_in), .q_valid(q_valid),
    .disc_out(disc1), .chip_out(chip1), .out_valid(vld1), .sync_err(serr1)
  );

  iq_freq_discriminator #(.DECIM(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .i_in(i_in), .i_valid(i_valid), .q_in(q_in), .q_valid(q_valid),
    .disc_out(disc2), .chip_out(chip2), .out_valid(vld2), .sync_err(serr2)
  );

  typedef struct {
    int i;
    int q;
    bit ev;
    int ed;
    bit ec;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Simultaneous I/Q strobe, then look for the single out_valid at +2 cycles.
  task automatic apply_pair(input int iv, input int qv, input bit ev,
                            input int ed, input bit ec, input string tag);
    @(negedge clk);
    i_in = 5'(iv); q_in = 5'(qv); i_valid = 1'b1; q_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; q_valid = 1'b0;
    chk({tag, ".early"}, int'(vld1), 0);
    @(negedge clk);
    chk({tag, ".vld"}, int'(vld1), int'(ev));
    if (ev) begin
      chk({tag, ".disc"}, int'(disc1), ed);
      chk({tag, ".chip"}, int'(chip1), int'(ec));
    end
    @(negedge clk);
    chk({tag, ".one"}, int'(vld1), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_in = '0; q_in = '0; i_valid = 1'b0; q_valid = 1'b0;
    tbl[0] = '{10,   0, 1'b0,    0, 1'b0};
    tbl[1] = '{0,   10, 1'b1,  100, 1'b1};
    tbl[2] = '{10,   0, 1'b1, -100, 1'b0};
    tbl[3] = '{10,   0, 1'b1,    0, 1'b0};
    tbl[4] = '{-16, -16, 1'b1, -160, 1'b0};
    tbl[5] = '{-16, 15, 1'b1, -496, 1'b0};
    tbl[6] = '{-16, -16, 1'b1,  496, 1'b1};
    tbl[7] = '{0,    0, 1'b1,    0, 1'b1};
    tbl[8] = '{3,   -5, 1'b1,    0, 1'b1};
    tbl[9] = '{-7,   2, 1'b1,  -29, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.vld",  int'(vld1),  0);
    chk("rst.disc", int'(disc1), 0);
    chk("rst.chip", int'(chip1), 0);
    chk("rst.serr", int'(serr1), 0);

    for (int k = 0; k < 10; k++) begin
      apply_pair(tbl[k].i, tbl[k].q, tbl[k].ev, tbl[k].ed, tbl[k].ec,
                 $sformatf("vec%0d", k));
    end
    chk("vec.serr", int'(serr1), 0);

    // Skew: I alone, Q three cycles later; prev pair (-7,2) -> -7*4 - 2*5
    @(negedge clk); i_in = 5'sd5; i_valid = 1'b1;
    @(negedge clk); i_valid = 1'b0; chk("skew.c1", int'(vld1), 0);
    @(negedge clk); chk("skew.c2", int'(vld1), 0);
    @(negedge clk); q_in = 5'sd4; q_valid = 1'b1; chk("skew.c3", int'(vld1), 0);
    @(negedge clk); q_valid = 1'b0; chk("skew.c4", int'(vld1), 0);
    @(negedge clk);
    chk("skew.vld",  int'(vld1),  1);
    chk("skew.disc", int'(disc1), -38);
    chk("skew.chip", int'(chip1), 0);
    chk("skew.serr", int'(serr1), 0);
    @(negedge clk); chk("skew.one", int'(vld1), 0);
    repeat (2) @(negedge clk);

    // Double I strobe: error is sticky and the second I is paired; prev (5,4)
    @(negedge clk); i_in = 5'sd1; i_valid = 1'b1;
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk); i_in = 5'sd6; i_valid = 1'b1;
    @(negedge clk); i_valid = 1'b0; chk("err.set", int'(serr1), 1);
    chk("err.novld", int'(vld1), 0);
    @(negedge clk); q_in = -5'sd3; q_valid = 1'b1;
    @(negedge clk); q_valid = 1'b0;
    @(negedge clk);
    chk("err.vld",  int'(vld1),  1);
    chk("err.disc", int'(disc1), -39);
    chk("err.chip", int'(chip1), 0);
    repeat (4) @(negedge clk);
    chk("err.sticky", int'(serr1), 1);

    // Reset one cycle after a pair forms: pair is discarded
    @(negedge clk); i_in = 5'sd2; q_in = 5'sd3; i_valid = 1'b1; q_valid = 1'b1;
    @(negedge clk); i_valid = 1'b0; q_valid = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mrst.vld",  int'(vld1),  0);
    chk("mrst.disc", int'(disc1), 0);
    chk("mrst.chip", int'(chip1), 0);
    chk("mrst.serr", int'(serr1), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mrst.quiet%0d", c), int'(vld1), 0);
    end
    apply_pair(1, 1, 1'b0, 0, 1'b0, "mrst.p0");
    apply_pair(-1, 2, 1'b1, 3, 1'b1, "mrst.p1");

    // Decimation by 4 over 13 computed pairs, DECIM=1 instance as reference
    do_reset();
    begin
      int ip, qp, iv, qv, d, pulses;
      bit c1, c2, emit2;
      ip = 0; qp = 0; pulses = 0; c1 = 1'b0; c2 = 1'b0;
      for (int k = 0; k < 14; k++) begin
        iv = ((k * 7) % 32) - 16;
        qv = ((k * 11 + 5) % 32) - 16;
        d  = ip * qv - qp * iv;
        emit2 = (k > 0) && (((k - 1) % 4) == 0);
        if (k > 0 && d > 0) c1 = 1'b1;
        if (k > 0 && d < 0) c1 = 1'b0;
        if (emit2 && d > 0) c2 = 1'b1;
        if (emit2 && d < 0) c2 = 1'b0;
        @(negedge clk);
        i_in = 5'(iv); q_in = 5'(qv); i_valid = 1'b1; q_valid = 1'b1;
        pulses += int'(vld2);
        @(negedge clk);
        i_valid = 1'b0; q_valid = 1'b0;
        pulses += int'(vld2);
        @(negedge clk);
        pulses += int'(vld2);
        chk($sformatf("dec%0d.vld1", k), int'(vld1), int'(k > 0));
        chk($sformatf("dec%0d.vld4", k), int'(vld2), int'(emit2));
        if (k > 0) begin
          chk($sformatf("dec%0d.disc1", k), int'(disc1), d);
          chk($sformatf("dec%0d.chip1", k), int'(chip1), int'(c1));
        end
        if (emit2) begin
          chk($sformatf("dec%0d.disc4", k), int'(disc2), d);
          chk($sformatf("dec%0d.chip4", k), int'(chip2), int'(c2));
        end
        @(negedge clk);
        pulses += int'(vld2);
        @(negedge clk);
        pulses += int'(vld2);
        ip = iv; qp = qv;
      end
      chk("dec.pulses", pulses, 4);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
